// File: rtl/ccsds123_header_inserter_pkg.sv
// Shared types and header byte layout for the CCSDS-123 image header inserter.
// The tb decoder and the RTL both build the 8-byte header from these offsets.
package ccsds123_header_inserter_pkg;

  localparam int HDR_BYTES = 8;
  localparam int B_NX      = 0;
  localparam int B_NY      = 2;
  localparam int B_NZ      = 4;
  localparam int B_D       = 6;
  localparam int B_FLAGS   = 7;

  typedef enum logic [1:0] {
    HDR_WAIT,
    HDR,
    BODY,
    DRAIN
  } state_t;

  function automatic logic [8*HDR_BYTES-1:0] hdr_pack(
    input int nx,
    input int ny,
    input int nz,
    input int d,
    input bit isu,
    input bit col
  );
    logic [8*HDR_BYTES-1:0] h;
    h = '0;
    h[8*B_NX +: 16]   = 16'(nx - 1);
    h[8*B_NY +: 16]   = 16'(ny - 1);
    h[8*B_NZ +: 16]   = 16'(nz - 1);
    h[8*B_D +: 4]     = 4'(d % 16);
    h[8*B_FLAGS +: 8] = {6'b0, col, isu};
    return h;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered output, full throughput,
// one cycle from input handshake to output valid.
module axis_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] sk_data;
  logic             sk_valid;

  assign in_ready = !sk_valid;

  always_ff @(posedge clk) begin
    if (areset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sk_data   <= '0;
      sk_valid  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (sk_valid) begin
        out_data  <= sk_data;
        out_valid <= 1'b1;
        sk_valid  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      // output stalled: park the new word in the second slot
      sk_data  <= in_data;
      sk_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ccsds123_header_inserter.sv
// Prefixes each compressed image with an 8-byte header, then forwards
// the body words through a skid buffer; counts frames and body words.
module ccsds123_header_inserter
  import ccsds123_header_inserter_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int NX           = 500,
  parameter int NY           = 500,
  parameter int NZ           = 100,
  parameter int D            = 16,
  parameter int ISUNSIGNED   = 0,
  parameter int COL_ORIENTED = 0
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [15:0]          frame_count,
  output logic [31:0]          body_words
);

  localparam int HDR_WORDS = 8 * HDR_BYTES / BUS_WIDTH;
  localparam int IDX_W =
    (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(HDR_WORDS - 1);
  localparam logic [8*HDR_BYTES-1:0] HDR_WORD =
    hdr_pack(NX, NY, NZ, D,
             ISUNSIGNED != 0, COL_ORIENTED != 0);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [31:0]      run_cnt;
  logic [31:0]      run_inc;

  logic [8*HDR_BYTES-1:0] hdr_sh;
  logic [BUS_WIDTH-1:0]   hdr_word;

  logic               sk_in_valid;
  logic               sk_in_ready;
  logic [BUS_WIDTH:0] sk_out;
  logic               sk_valid;
  logic               sk_last;
  logic               body_hs;

  assign sk_last = sk_out[BUS_WIDTH];
  assign sk_in_valid =
    s_axis_tvalid && (state == BODY);
  assign s_axis_tready =
    (state == BODY) && sk_in_ready;

  axis_skid_buffer #(
    .WIDTH(BUS_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .areset    (areset),
    .in_data   ({s_axis_tlast, s_axis_tdata}),
    .in_valid  (sk_in_valid),
    .in_ready  (sk_in_ready),
    .out_data  (sk_out),
    .out_valid (sk_valid),
    .out_ready (m_axis_tready)
  );

  always_comb begin
    hdr_sh   = HDR_WORD >> (BUS_WIDTH * int'(idx));
    hdr_word = hdr_sh[BUS_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= HDR_WAIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state)
      HDR_WAIT: begin
        // peek only: the word stays upstream until BODY
        if (s_axis_tvalid) state_nx = HDR;
      end
      HDR: begin
        m_axis_tdata  = hdr_word;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          if (idx == LAST_IDX) begin
            state_nx = BODY;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      BODY: begin
        m_axis_tdata  = sk_out[BUS_WIDTH-1:0];
        m_axis_tvalid = sk_valid;
        m_axis_tlast  = sk_last;
        if (s_axis_tvalid && s_axis_tready
            && s_axis_tlast)
          state_nx = DRAIN;
      end
      DRAIN: begin
        m_axis_tdata  = sk_out[BUS_WIDTH-1:0];
        m_axis_tvalid = sk_valid;
        m_axis_tlast  = sk_last;
        if (sk_valid && m_axis_tready && sk_last)
          state_nx = HDR_WAIT;
      end
    endcase
  end

  assign body_hs = ((state == BODY) || (state == DRAIN))
                   && sk_valid && m_axis_tready;
  assign run_inc = (&run_cnt) ? run_cnt : run_cnt + 1;

  always_ff @(posedge clk) begin
    if (areset) begin
      run_cnt     <= '0;
      frame_count <= '0;
      body_words  <= '0;
    end else if (body_hs) begin
      if (state == DRAIN && sk_last) begin
        frame_count <= frame_count + 1'b1;
        body_words  <= run_inc;
        run_cnt     <= '0;
      end else begin
        run_cnt <= run_inc;
      end
    end
  end

endmodule
